// File: rtl/osc_bank_pkg.sv
// Shared types and helpers for the oscillator bank.
// Time quantities are handled here at a generous maximum width; modules narrow them to DT_WIDTH.
package osc_bank_pkg;

   localparam int unsigned DT_W_MAX = 64;

   localparam logic [DT_W_MAX-1:0] DT_MAX = '1;

   typedef struct packed {
      logic                en;
      logic [DT_W_MAX-1:0] hi;
      logic [DT_W_MAX-1:0] lo;
   } osc_cfg_t;

   // A zero half-period would stall the channel on a permanent edge, so it is stored as 1.
   function automatic logic [DT_W_MAX-1:0] sat_period(input logic [DT_W_MAX-1:0] p);
      return (p == '0) ? DT_W_MAX'(1) : p;
   endfunction

endpackage

// File: rtl/osc_chan.sv
// One emulated clock channel: active periods, a pending configuration slot and the edge logic.
// A pending slot is applied at once on a disabled channel, otherwise only at the channel's next edge.
module osc_chan
   import osc_bank_pkg::*;
#(
   parameter int unsigned DT_WIDTH = 27,
   parameter int unsigned DEF_HI   = 1000,
   parameter int unsigned DEF_LO   = 1000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [DT_WIDTH-1:0] dt_i,
   input  logic                wr_i,
   input  logic                cfg_en_i,
   input  logic [DT_WIDTH-1:0] cfg_hi_i,
   input  logic [DT_WIDTH-1:0] cfg_lo_i,
   output logic                clk_val_o,
   output logic [DT_WIDTH-1:0] dt_req_o,
   output logic                err_o
);

   logic                en_q, en_d;
   logic                clk_q, clk_d;
   logic                err_q, err_d;
   logic [DT_WIDTH-1:0] rem_q, rem_d;
   logic [DT_WIDTH-1:0] hi_q, hi_d;
   logic [DT_WIDTH-1:0] lo_q, lo_d;
   logic                pend_valid_q, pend_valid_d;
   logic                pend_en_q, pend_en_d;
   logic [DT_WIDTH-1:0] pend_hi_q, pend_hi_d;
   logic [DT_WIDTH-1:0] pend_lo_q, pend_lo_d;

   logic                edge_hit;
   logic                overshoot;
   logic                new_clk;
   logic [DT_WIDTH-1:0] hi_sel;
   logic [DT_WIDTH-1:0] lo_sel;

   assign edge_hit  = en_q && (dt_i >= rem_q);
   assign overshoot = en_q && (dt_i > rem_q);

   always_comb begin
      en_d         = en_q;
      clk_d        = clk_q;
      err_d        = err_q;
      rem_d        = rem_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      pend_valid_d = pend_valid_q;
      pend_en_d    = pend_en_q;
      pend_hi_d    = pend_hi_q;
      pend_lo_d    = pend_lo_q;
      new_clk      = ~clk_q;
      hi_sel       = pend_valid_q ? pend_hi_q : hi_q;
      lo_sel       = pend_valid_q ? pend_lo_q : lo_q;

      if (!en_q) begin
         if (pend_valid_q) begin
            pend_valid_d = 1'b0;
            if (pend_en_q) begin
               en_d  = 1'b1;
               clk_d = 1'b0;
               hi_d  = pend_hi_q;
               lo_d  = pend_lo_q;
               rem_d = pend_lo_q;
            end
         end
      end else if (edge_hit) begin
         if (overshoot) begin
            err_d = 1'b1;
         end
         pend_valid_d = 1'b0;
         if (pend_valid_q && !pend_en_q) begin
            en_d  = 1'b0;
            clk_d = 1'b0;
         end else begin
            clk_d = new_clk;
            hi_d  = hi_sel;
            lo_d  = lo_sel;
            rem_d = new_clk ? hi_sel : lo_sel;
         end
      end else begin
         rem_d = rem_q - dt_i;
      end

      // A write lands after any consumption above, so a write coinciding with an edge waits for the next one.
      if (wr_i) begin
         pend_valid_d = 1'b1;
         pend_en_d    = cfg_en_i;
         pend_hi_d    = DT_WIDTH'(sat_period(DT_W_MAX'(cfg_hi_i)));
         pend_lo_d    = DT_WIDTH'(sat_period(DT_W_MAX'(cfg_lo_i)));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         en_q         <= 1'b0;
         clk_q        <= 1'b0;
         err_q        <= 1'b0;
         rem_q        <= DT_WIDTH'(DEF_LO);
         hi_q         <= DT_WIDTH'(DEF_HI);
         lo_q         <= DT_WIDTH'(DEF_LO);
         pend_valid_q <= 1'b0;
         pend_en_q    <= 1'b0;
         pend_hi_q    <= DT_WIDTH'(DEF_HI);
         pend_lo_q    <= DT_WIDTH'(DEF_LO);
      end else begin
         en_q         <= en_d;
         clk_q        <= clk_d;
         err_q        <= err_d;
         rem_q        <= rem_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         pend_valid_q <= pend_valid_d;
         pend_en_q    <= pend_en_d;
         pend_hi_q    <= pend_hi_d;
         pend_lo_q    <= pend_lo_d;
      end
   end

   assign clk_val_o = clk_q;
   assign dt_req_o  = en_q ? rem_q : DT_WIDTH'(DT_MAX);
   assign err_o     = err_q;

endmodule

// File: rtl/osc_bank.sv
// Bank of emulated clock oscillators exporting per-channel and minimum timestep requests.
// cfg_valid is a write strobe with no ready: every write is accepted into the target channel's pending slot.
module osc_bank
   import osc_bank_pkg::*;
#(
   parameter int unsigned N_CH     = 2,
   parameter int unsigned DT_WIDTH = 27,
   parameter int unsigned DEF_HI   = 1000,
   parameter int unsigned DEF_LO   = 1000,
   localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     emu_clk,
   input  logic                     emu_rst,
   input  logic [DT_WIDTH-1:0]      emu_dt,
   input  logic                     cfg_valid,
   input  logic [CH_W-1:0]          cfg_ch,
   input  logic                     cfg_en,
   input  logic [DT_WIDTH-1:0]      cfg_hi,
   input  logic [DT_WIDTH-1:0]      cfg_lo,
   output logic [N_CH-1:0]          clk_val,
   output logic [N_CH*DT_WIDTH-1:0] dt_req,
   output logic [DT_WIDTH-1:0]      dt_req_min,
   output logic [N_CH-1:0]          err_overshoot
);

   logic [DT_WIDTH-1:0] min_v;

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      logic wr;
      assign wr = cfg_valid && (cfg_ch == CH_W'(i));

      osc_chan #(
         .DT_WIDTH (DT_WIDTH),
         .DEF_HI   (DEF_HI),
         .DEF_LO   (DEF_LO)
      ) u_chan (
         .clk_i     (emu_clk),
         .rst_i     (emu_rst),
         .dt_i      (emu_dt),
         .wr_i      (wr),
         .cfg_en_i  (cfg_en),
         .cfg_hi_i  (cfg_hi),
         .cfg_lo_i  (cfg_lo),
         .clk_val_o (clk_val[i]),
         .dt_req_o  (dt_req[i*DT_WIDTH +: DT_WIDTH]),
         .err_o     (err_overshoot[i])
      );
   end

   // Purely combinational so the time manager can feed the minimum straight back as emu_dt.
   always_comb begin
      min_v = DT_WIDTH'(DT_MAX);
      for (int i = 0; i < N_CH; i++) begin
         if (dt_req[i*DT_WIDTH +: DT_WIDTH] < min_v) begin
            min_v = dt_req[i*DT_WIDTH +: DT_WIDTH];
         end
      end
   end

   assign dt_req_min = min_v;

endmodule

// File: tb/tb_osc_bank.sv
// Directed plus randomized bench for osc_bank, checked against an absolute-time reference model.
module tb_osc_bank;
   import osc_bank_pkg::*;

   localparam int     N    = 2;
   localparam int     W    = 27;
   localparam longint ONES = (longint'(1) << W) - 1;

   logic           emu_clk = 1'b0;
   logic           emu_rst = 1'b1;
   logic [W-1:0]   emu_dt = '0;
   logic           cfg_valid = 1'b0;
   logic           cfg_ch = 1'b0;
   logic           cfg_en = 1'b0;
   logic [W-1:0]   cfg_hi = '0;
   logic [W-1:0]   cfg_lo = '0;
   logic [N-1:0]   clk_val;
   logic [N*W-1:0] dt_req;
   logic [W-1:0]   dt_req_min;
   logic [N-1:0]   err_overshoot;

   int checks = 0;
   int failures = 0;

   osc_bank #(.N_CH(N), .DT_WIDTH(W), .DEF_HI(1000), .DEF_LO(1000)) dut (
      .emu_clk       (emu_clk),
      .emu_rst       (emu_rst),
      .emu_dt        (emu_dt),
      .cfg_valid     (cfg_valid),
      .cfg_ch        (cfg_ch),
      .cfg_en        (cfg_en),
      .cfg_hi        (cfg_hi),
      .cfg_lo        (cfg_lo),
      .clk_val       (clk_val),
      .dt_req        (dt_req),
      .dt_req_min    (dt_req_min),
      .err_overshoot (err_overshoot)
   );

   always #5 emu_clk = ~emu_clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: absolute emulated time and the absolute time of each channel's next edge.
   longint   m_time;
   bit       m_en [N];
   bit       m_clk [N];
   bit       m_err [N];
   bit       m_pv [N];
   osc_cfg_t m_pend [N];
   longint   m_hi [N];
   longint   m_lo [N];
   longint   m_next [N];

   function automatic longint m_req(int c);
      return m_en[c] ? (m_next[c] - m_time) : ONES;
   endfunction

   function automatic longint m_min();
      longint mn = ONES;
      for (int c = 0; c < N; c++) if (m_req(c) < mn) mn = m_req(c);
      return mn;
   endfunction

   task automatic model_reset();
      m_time = 0;
      for (int c = 0; c < N; c++) begin
         m_en[c] = 0; m_clk[c] = 0; m_err[c] = 0; m_pv[c] = 0;
         m_hi[c] = 1000; m_lo[c] = 1000; m_next[c] = 0;
         m_pend[c] = '0;
      end
   endtask

   task automatic model_cycle(longint dt, bit wr, int wc, bit wen, longint whi, longint wlo, bit rst);
      longint t_new;
      if (rst) begin
         model_reset();
         return;
      end
      t_new = m_time + dt;
      for (int c = 0; c < N; c++) begin
         if (!m_en[c]) begin
            if (m_pv[c]) begin
               m_pv[c] = 0;
               if (m_pend[c].en) begin
                  m_en[c] = 1; m_clk[c] = 0;
                  m_hi[c] = longint'(m_pend[c].hi); m_lo[c] = longint'(m_pend[c].lo);
                  m_next[c] = t_new + m_lo[c];
               end
            end
         end else if (t_new >= m_next[c]) begin
            if (t_new > m_next[c]) m_err[c] = 1;
            if (m_pv[c]) begin
               m_pv[c] = 0;
               if (!m_pend[c].en) begin
                  m_en[c] = 0; m_clk[c] = 0;
               end else begin
                  m_hi[c] = longint'(m_pend[c].hi); m_lo[c] = longint'(m_pend[c].lo);
               end
            end
            if (m_en[c]) begin
               m_clk[c] = !m_clk[c];
               m_next[c] = t_new + (m_clk[c] ? m_hi[c] : m_lo[c]);
            end
         end
      end
      if (wr) begin
         m_pend[wc].en = wen;
         m_pend[wc].hi = (whi == 0) ? 64'd1 : 64'(whi);
         m_pend[wc].lo = (wlo == 0) ? 64'd1 : 64'(wlo);
         m_pv[wc] = 1;
      end
      m_time = t_new;
   endtask

   task automatic expect_val(string tag, longint obs, longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [N-1:0] ec;
      logic [N-1:0] ee;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      for (int c = 0; c < N; c++) begin
         ec[c] = m_clk[c];
         ee[c] = m_err[c];
      end
      checks++;
      assert (clk_val === ec) else begin
         failures++;
         $error("FAIL clk_val: observed=%b expected=%b t=%0d", clk_val, ec, m_time);
      end
      checks++;
      assert (err_overshoot === ee) else begin
         failures++;
         $error("FAIL err_overshoot: observed=%b expected=%b t=%0d", err_overshoot, ee, m_time);
      end
      for (int c = 0; c < N; c++) begin
         got = dt_req[c*W +: W];
         exp = W'(m_req(c));
         checks++;
         assert (got === exp) else begin
            failures++;
            $error("FAIL dt_req[%0d]: observed=%0d expected=%0d t=%0d", c, got, exp, m_time);
         end
      end
      exp = W'(m_min());
      checks++;
      assert (dt_req_min === exp) else begin
         failures++;
         $error("FAIL dt_req_min: observed=%0d expected=%0d t=%0d", dt_req_min, exp, m_time);
      end
   endtask

   task automatic step(logic [W-1:0] dt, bit wr, int wc, bit wen, logic [W-1:0] whi, logic [W-1:0] wlo, bit rst);
      emu_dt    = dt;
      cfg_valid = wr;
      cfg_ch    = 1'(wc);
      cfg_en    = wen;
      cfg_hi    = whi;
      cfg_lo    = wlo;
      emu_rst   = rst;
      @(posedge emu_clk);
      model_cycle(longint'(dt), wr, wc, wen, longint'(whi), longint'(wlo), rst);
      #1;
      cfg_valid = 1'b0;
      emu_rst   = 1'b0;
      check_all();
   endtask

   task automatic run(logic [W-1:0] dt);
      step(dt, 0, 0, 0, '0, '0, 0);
   endtask

   task automatic go();
      run(W'(m_min()));
   endtask

   task automatic bound_check(string tag, bit found);
      checks++;
      assert (found) else begin
         failures++;
         $error("FAIL %s: bound expired observed=0 expected=1", tag);
      end
   endtask

   initial begin
      bit     found;
      bit     prev;
      int     r;
      int     k;
      longint mn;
      logic [W-1:0] dt;

      model_reset();
      // Reset state
      step('0, 0, 0, 0, '0, '0, 1);
      step('0, 0, 0, 0, '0, '0, 1);
      expect_val("reset_min", longint'(dt_req_min), ONES);
      expect_val("reset_clk", longint'(clk_val), 0);

      // Enable both channels at emulated time 0
      step('0, 1, 0, 1, W'(5), W'(5), 0);
      step('0, 1, 1, 1, W'(3), W'(7), 0);
      run('0);
      expect_val("en_req0", longint'(dt_req[0 +: W]), 5);
      expect_val("en_req1", longint'(dt_req[W +: W]), 7);
      go(); expect_val("t5_clk", longint'(clk_val), 2'b01);
      go(); expect_val("t7_clk", longint'(clk_val), 2'b11);
      go(); expect_val("t10_clk", longint'(clk_val), 2'b00);
      go(); expect_val("t15_clk", longint'(clk_val), 2'b01);
      go(); expect_val("t17_clk", longint'(clk_val), 2'b11);
      for (int i = 0; i < 10; i++) go();
      expect_val("no_err", longint'(err_overshoot), 0);

      // Hold with zero timestep
      for (int i = 0; i < 10; i++) run('0);

      // Reconfigure ch0 mid-phase with 3 left
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_req(0) > 3 && (m_req(0) - 3) <= m_req(1)) found = 1;
         else go();
      end
      bound_check("reach_mid_phase", found);
      run(W'(m_req(0) - 3));
      expect_val("mid_rem3", longint'(dt_req[0 +: W]), 3);
      step('0, 1, 0, 1, W'(2), W'(2), 0);
      for (int i = 0; i < 10; i++) go();

      // Overshoot on ch0
      step('0, 1, 0, 1, W'(4), W'(4), 0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         go();
         if (m_en[0] && !m_pv[0] && m_req(0) == 4) found = 1;
      end
      bound_check("reach_rem4", found);
      prev = m_clk[0];
      run(W'(6));
      expect_val("ovs_err0", longint'(err_overshoot[0]), 1);
      expect_val("ovs_toggle", longint'(clk_val[0]), longint'(!prev));
      for (int i = 0; i < 6; i++) go();
      expect_val("ovs_sticky", longint'(err_overshoot[0]), 1);

      // Disable ch1 with a write coinciding with its edge
      prev = m_clk[1];
      step(W'(m_req(1)), 1, 1, 0, '0, '0, 0);
      expect_val("dis_toggle", longint'(clk_val[1]), longint'(!prev));
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         go();
         if (!m_en[1]) found = 1;
      end
      bound_check("reach_disable", found);
      expect_val("dis_req1", longint'(dt_req[W +: W]), ONES);
      for (int i = 0; i < 5; i++) go();

      // Zero high period is stored as 1, then reset mid-run
      step('0, 1, 0, 1, '0, W'(3), 0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         go();
         if (m_en[0] && m_clk[0] && m_hi[0] == 1 && m_req(0) == 1) found = 1;
      end
      bound_check("reach_hi1", found);
      expect_val("zero_hi", longint'(dt_req[0 +: W]), 1);
      go(); go();
      step(W'(m_min()), 1, 1, 1, W'(4), W'(4), 1);
      expect_val("rst_clk", longint'(clk_val), 0);
      expect_val("rst_err", longint'(err_overshoot), 0);
      expect_val("rst_min", longint'(dt_req_min), ONES);
      run('0); run('0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r  = int'($urandom_range(0, 199));
         mn = m_min();
         if (mn == ONES) begin
            dt = W'($urandom_range(0, 20));
         end else begin
            k = int'($urandom_range(0, 9));
            if (k < 6) dt = W'(mn);
            else if (k < 9) dt = W'($urandom_range(0, 32'(mn)));
            else dt = W'(mn + longint'($urandom_range(1, 3)));
         end
         step(dt, (r >= 1 && r <= 12), int'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0),
              W'($urandom_range(0, 12)), W'($urandom_range(0, 12)), (r == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/osc_bank.md
# osc_bank

Multi-channel, parametrised oscillator bank for multi-clock emulation. Each channel generates one emulated clock signal (`clk_val[ch]`) with a programmable high and low half-period. Every `emu_clk` cycle, each channel advances its time-to-next-edge by the global timestep `emu_dt` and presents its remaining time as a timestep request. The bank also exports the minimum request across all channels, so the time manager can pick the next `emu_dt` without missing any clock edge.

## Interface

Parameters:
- `N_CH`, 2: number of oscillator channels (1..16).
- `DT_WIDTH`, 27: width of all time quantities (unsigned, in dt LSBs).
- `DEF_HI`, 1000: reset value of every channel's high half-period.
- `DEF_LO`, 1000: reset value of every channel's low half-period.

Ports:
- `emu_clk` input 1: emulator clock.
- `emu_rst` input 1: reset; **synchronous, active-high**.
- `emu_dt` input DT_WIDTH: timestep applied in this cycle (0 = no time advance).
- `cfg_valid` input 1: configuration write strobe.
- `cfg_ch` input $clog2(N_CH): target channel.
- `cfg_en` input 1: channel enable value.
- `cfg_hi` input DT_WIDTH: new high half-period.
- `cfg_lo` input DT_WIDTH: new low half-period.
- `clk_val` output N_CH: emulated clock values.
- `dt_req` output N_CH*DT_WIDTH: per-channel remaining time; channel `ch` occupies bits `[ch*DT_WIDTH +: DT_WIDTH]`.
- `dt_req_min` output DT_WIDTH: minimum of all `dt_req`.
- `err_overshoot` output N_CH: sticky flag per channel, set when `emu_dt` exceeded that channel's remaining time.

## Operation

Per-channel state:
- `en`, `clk_val`, `remaining`.
- Active periods: `hi`, `lo`.
- Pending configuration: `pend_valid`, `pend_en`, `pend_hi`, `pend_lo`.

Reset values:
- `en=0`, `clk_val=0`, `remaining=DEF_LO`, `hi=DEF_HI`, `lo=DEF_LO`, `pend_valid=0`, `err_overshoot=0`.
- `dt_req` is all-ones for every channel (all disabled), so `dt_req_min` is also all-ones.

Configuration writes:
- A `cfg_valid` write in cycle t stores `{cfg_en, cfg_hi, cfg_lo}` into the pending slot of `cfg_ch`; `pend_valid=1` from cycle t+1.
- A second write before the pending slot is consumed overwrites it (last write wins).
- There is no backpressure: every write is accepted.
- A period value of 0 is clamped to 1 when stored.

When a pending configuration is applied:
- **Channel disabled:** it is applied in the next cycle. If `pend_en=1`, set `en=1`, `clk_val=0`, `remaining=pend_lo`.
- **Channel enabled:** it is applied only at that channel's next edge, which keeps output changes glitch-free.
  - If `pend_en=0` at the edge, set `en=0` and `clk_val=0`.
  - Otherwise load `hi`/`lo` from the pending slot, then reload `remaining` as in the edge rules below.

Per enabled channel, each cycle (let `r = remaining`):
- `emu_dt < r`: `remaining <= r - emu_dt`.
- `emu_dt == r` (an edge): toggle `clk_val`, then reload `remaining` with `hi` if the new `clk_val` is 1, else `lo`.
- `emu_dt > r`: behave exactly as an edge, and additionally set `err_overshoot[ch]`. The flag clears only on `emu_rst`.

Request outputs:
- `dt_req[ch] = remaining` when enabled, all-ones when disabled.
- `dt_req_min` is the unsigned minimum over all channels; ties are irrelevant.
- Arithmetic is unsigned, DT_WIDTH bits, and never wraps: the subtraction only occurs when `emu_dt < r`.

## Timing

- `clk_val`, `dt_req` and `err_overshoot` are registered and update one `emu_clk` edge after the `emu_dt` that causes the change.
- `dt_req_min` is combinational from the registered `dt_req`, so it is valid in the same cycle. This lets the time manager feed `emu_dt = dt_req_min` back with zero latency.
- Simultaneous configuration write and edge on the same channel in cycle t: the edge uses the state from before the write; the new values are applied at the following edge.
- Reset mid-operation: all state returns to its reset values on the next edge, and any pending configuration is discarded.

## Structure

- Package `osc_bank_pkg`:
  - `osc_cfg_t` struct `{en, hi, lo}`.
  - `DT_MAX` constant.
  - Function `sat_period()` implementing the 0→1 clamp.
- Sub-module `osc_chan`: one channel with its state, pending slot and edge logic, instantiated N_CH times in a generate loop.
- The top level holds the `cfg_ch` decode and the min-reduction tree.

## Test plan

All scenarios use `N_CH=2`, `DT_WIDTH=27`.

1. **Enable both channels.** ch0 gets hi=lo=5; ch1 gets hi=3, lo=7. Drive `emu_dt = dt_req_min` every cycle.
   - ch0 toggles at emulated times 5, 10, 15…
   - ch1 goes high at 7, low at 10, high at 17.
   - `err_overshoot` stays 00.
2. **emu_dt = 0 for 10 cycles.**
   - `dt_req` and `clk_val` hold constant.
3. **Reconfigure mid-phase.** ch0 runs at 5/5; write hi=lo=2 while `remaining=3`.
   - The current phase still ends after 3.
   - Subsequent toggles come every 2.
4. **Overshoot.** ch0 has `remaining=4`; force `emu_dt=6`.
   - `clk_val[0]` toggles and `err_overshoot[0]=1`.
   - The flag persists until `emu_rst`.
5. **Disable with simultaneous write.** Write `cfg_en=0` to ch1 in the same cycle as a ch1 edge.
   - The edge toggles normally.
   - ch1 disables at its next edge, with `dt_req[1]=all-ones`.
   - `dt_req_min` then follows ch0 alone.
6. **Zero period and reset.** Write hi=0.
   - The stored hi becomes 1.
   - Assert `emu_rst` for 1 cycle mid-run: all outputs return to their reset values on the next edge.
